// File: rtl/aes128_cipher_ctrl.sv
// aes128_cipher_ctrl: sequencer and on-the-fly AES-128 key scheduler for an
// iterative Cipher core. The block encrypts one block at a time.
//
// Ports:
//   CLK, RST                   clock / synchronous active-low reset
//   start_in, ready_out        block request handshake (ready only in C_IDLE)
//   pt0_in..pt3_in             plaintext words, pt0 most significant
//   key0_in..key3_in           cipher key words, key0 most significant
//   ct_valid_out, ct_ack_in    ciphertext hold / consumer acknowledge
//   ct0_out..ct3_out           captured ciphertext
//   err_out                    sticky missing-core-valid error
//   core_state_out             Cipher state: 0 idle, 1 round0, 2 rounds 1-9, 3 round10
//   core_pt*_out, core_key*_out  latched plaintext / current round key to Cipher
//   core_ct*_in, core_valid_in   Cipher result
module aes128_cipher_ctrl #(
  parameter bit ERR_CHECK = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start_in,
  input  logic [31:0] pt0_in,
  input  logic [31:0] pt1_in,
  input  logic [31:0] pt2_in,
  input  logic [31:0] pt3_in,
  input  logic [31:0] key0_in,
  input  logic [31:0] key1_in,
  input  logic [31:0] key2_in,
  input  logic [31:0] key3_in,
  output logic        ready_out,
  output logic        ct_valid_out,
  input  logic        ct_ack_in,
  output logic [31:0] ct0_out,
  output logic [31:0] ct1_out,
  output logic [31:0] ct2_out,
  output logic [31:0] ct3_out,
  output logic        err_out,
  output logic [1:0]  core_state_out,
  output logic [31:0] core_pt0_out,
  output logic [31:0] core_pt1_out,
  output logic [31:0] core_pt2_out,
  output logic [31:0] core_pt3_out,
  output logic [31:0] core_key0_out,
  output logic [31:0] core_key1_out,
  output logic [31:0] core_key2_out,
  output logic [31:0] core_key3_out,
  input  logic [31:0] core_ct0_in,
  input  logic [31:0] core_ct1_in,
  input  logic [31:0] core_ct2_in,
  input  logic [31:0] core_ct3_in,
  input  logic        core_valid_in
);

  typedef enum logic [2:0] {C_IDLE, C_R0, C_R19, C_R10, C_CAP, C_DONE} state_t;
  // element 0 is word 0 (most significant)
  typedef logic [0:3][31:0] blk_t;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic blk_t expand(input blk_t k, input logic [7:0] rc);
    logic [31:0] t;
    blk_t        n;
    t    = sub_word({k[3][23:0], k[3][31:24]}) ^ {rc, 24'h0};
    n[0] = k[0] ^ t;
    n[1] = k[1] ^ n[0];
    n[2] = k[2] ^ n[1];
    n[3] = k[3] ^ n[2];
    return n;
  endfunction

  state_t      state_q, state_d;
  blk_t        pt_q, rk_q, ct_q;
  logic [7:0]  rcon_q;
  logic [3:0]  cnt_q;
  logic        err_q;
  logic        accept;

  assign accept = start_in & ready_out;

  // state register
  always_ff @(posedge CLK) begin
    if (!RST) state_q <= C_IDLE;
    else      state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      C_IDLE:  if (accept) state_d = C_R0;
      C_R0:    state_d = C_R19;
      C_R19:   if (cnt_q == 4'd9) state_d = C_R10;
      C_R10:   state_d = C_CAP;
      C_CAP:   state_d = C_DONE;
      C_DONE:  if (ct_ack_in) state_d = C_IDLE;
      default: state_d = C_IDLE;
    endcase
  end

  // outputs decoded from state
  always_comb begin
    ready_out      = 1'b0;
    ct_valid_out   = 1'b0;
    core_state_out = 2'd0;
    unique case (state_q)
      C_IDLE:  ready_out      = 1'b1;
      C_R0:    core_state_out = 2'd1;
      C_R19:   core_state_out = 2'd2;
      C_R10:   core_state_out = 2'd3;
      C_DONE:  ct_valid_out   = 1'b1;
      default: ;
    endcase
  end

  // datapath: rk always holds the key the core needs in the current cycle,
  // so each round edge advances it one step of the schedule.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      pt_q   <= '0;
      rk_q   <= '0;
      ct_q   <= '0;
      rcon_q <= 8'h01;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      unique case (state_q)
        C_IDLE: if (accept) begin
          pt_q   <= {pt0_in, pt1_in, pt2_in, pt3_in};
          rk_q   <= {key0_in, key1_in, key2_in, key3_in};
          rcon_q <= 8'h01;
          cnt_q  <= '0;
          err_q  <= 1'b0;
        end
        C_R0, C_R19: begin
          rk_q   <= expand(rk_q, rcon_q);
          rcon_q <= xtime(rcon_q);
          cnt_q  <= (state_q == C_R0) ? 4'd1 : cnt_q + 4'd1;
        end
        C_CAP: begin
          ct_q <= {core_ct0_in, core_ct1_in, core_ct2_in, core_ct3_in};
          if (ERR_CHECK && !core_valid_in) err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign {ct0_out, ct1_out, ct2_out, ct3_out}                 = ct_q;
  assign {core_pt0_out, core_pt1_out, core_pt2_out, core_pt3_out} = pt_q;
  assign {core_key0_out, core_key1_out, core_key2_out, core_key3_out} = rk_q;
  assign err_out = err_q;

endmodule

// File: tb/tb_aes128_cipher_ctrl.sv
// Bench for aes128_cipher_ctrl: a behavioural iterative AES core follows
// core_state_out/core_key, so ciphertexts check the whole key schedule
// against published FIPS-197 / SP800-38A vectors.
module tb_aes128_cipher_ctrl;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  logic         start_in = 1'b0, ct_ack_in = 1'b0;
  logic [127:0] pt = '0, key = '0;
  logic         ready_out, ct_valid_out, err_out, core_valid_in;
  logic [1:0]   core_state_out;
  logic [31:0]  ct0, ct1, ct2, ct3, cp0, cp1, cp2, cp3, ck0, ck1, ck2, ck3;
  logic [127:0] ct, core_pt, core_key, core_ct;

  assign ct       = {ct0, ct1, ct2, ct3};
  assign core_pt  = {cp0, cp1, cp2, cp3};
  assign core_key = {ck0, ck1, ck2, ck3};

  aes128_cipher_ctrl #(.ERR_CHECK(1'b1)) dut (
    .CLK(CLK), .RST(RST), .start_in(start_in),
    .pt0_in(pt[127:96]), .pt1_in(pt[95:64]), .pt2_in(pt[63:32]), .pt3_in(pt[31:0]),
    .key0_in(key[127:96]), .key1_in(key[95:64]), .key2_in(key[63:32]), .key3_in(key[31:0]),
    .ready_out(ready_out), .ct_valid_out(ct_valid_out), .ct_ack_in(ct_ack_in),
    .ct0_out(ct0), .ct1_out(ct1), .ct2_out(ct2), .ct3_out(ct3),
    .err_out(err_out), .core_state_out(core_state_out),
    .core_pt0_out(cp0), .core_pt1_out(cp1), .core_pt2_out(cp2), .core_pt3_out(cp3),
    .core_key0_out(ck0), .core_key1_out(ck1), .core_key2_out(ck2), .core_key3_out(ck3),
    .core_ct0_in(core_ct[127:96]), .core_ct1_in(core_ct[95:64]),
    .core_ct2_in(core_ct[63:32]), .core_ct3_in(core_ct[31:0]),
    .core_valid_in(core_valid_in)
  );

  // ---------------- behavioural Cipher core ----------------
  localparam logic [0:255][7:0] SB = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // byte i = column i/4, row i%4, byte 0 most significant
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input bit mix);
    logic [7:0] b [16];
    logic [7:0] t [16];
    logic [127:0] r;
    for (int i = 0; i < 16; i++) b[i] = SB[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++) t[c*4+w] = b[((c+w)%4)*4 + w];
    if (mix) begin
      for (int c = 0; c < 4; c++) begin
        logic [7:0] a0, a1, a2, a3;
        a0 = t[c*4]; a1 = t[c*4+1]; a2 = t[c*4+2]; a3 = t[c*4+3];
        t[c*4]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        t[c*4+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        t[c*4+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        t[c*4+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = t[i];
    return r ^ k;
  endfunction

  logic [127:0] cs_q;
  logic         cv_q;
  logic         force_inv = 1'b0;
  assign core_ct       = cs_q;
  assign core_valid_in = cv_q & ~force_inv;

  always @(posedge CLK) begin
    if (!RST) begin
      cs_q <= '0;
      cv_q <= 1'b0;
    end else begin
      cv_q <= 1'b0;
      case (core_state_out)
        2'd1: cs_q <= core_pt ^ core_key;
        2'd2: cs_q <= aes_round(cs_q, core_key, 1'b1);
        2'd3: begin cs_q <= aes_round(cs_q, core_key, 1'b0); cv_q <= 1'b1; end
        default: ;
      endcase
    end
  end

  // ---------------- checking ----------------
  typedef struct {
    logic [127:0] pt, key, ct, rk1, rk10;
  } vec_t;
  vec_t vecs [3];

  int n_cmp = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_cs(input int k);
    if (k == 0) return 2'd1;
    if (k <= 9) return 2'd2;
    if (k == 10) return 2'd3;
    return 2'd0;
  endfunction

  // Starts a block from C_IDLE (called #1 after an edge) and follows it to
  // the first C_DONE cycle. A stray ack in a round cycle must be ignored.
  task automatic run_block(input vec_t v, input logic exp_err);
    pt = v.pt; key = v.key; start_in = 1'b1;
    @(posedge CLK); #1;
    start_in = 1'b0;
    for (int k = 0; k <= 12; k++) begin
      if (k > 0) begin @(posedge CLK); #1; end
      ct_ack_in = 1'b0;
      chk($sformatf("core_state k=%0d", k), 128'(core_state_out), 128'(exp_cs(k)));
      if (k >= 11) chk($sformatf("ct_valid k=%0d", k), 128'(ct_valid_out), 128'(k == 12));
      if (k == 0) begin
        chk("ready_busy", 128'(ready_out), 128'(0));
        chk("err_clr_on_start", 128'(err_out), 128'(0));
        chk("rk0", core_key, v.key);
      end
      if (k == 1)  chk("rk1", core_key, v.rk1);
      if (k == 4)  ct_ack_in = 1'b1;
      if (k == 10) chk("rk10", core_key, v.rk10);
      if (k == 12) begin
        chk("ct", ct, v.ct);
        chk("pt_held", core_pt, v.pt);
        chk("err", 128'(err_out), 128'(exp_err));
      end
    end
  endtask

  task automatic ack_done(input logic with_start);
    ct_ack_in = 1'b1; start_in = with_start;
    @(posedge CLK); #1;
    ct_ack_in = 1'b0; start_in = 1'b0;
    chk("ready_after_ack", 128'(ready_out), 128'(1));
    chk("ct_valid_after_ack", 128'(ct_valid_out), 128'(0));
    chk("state_after_ack", 128'(core_state_out), 128'(0));
  endtask

  initial begin
    vecs[0] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
                128'h13111d7fe3944a17f307a78b4d2b30c5};
    vecs[1] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'h3925841d02dc09fbdc118597196a0b32, 128'ha0fafe1788542cb123a339392a6c7605,
                128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[2] = '{128'h6bc1bee22e409f96e93d7e117393172a, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'h3ad77bb40d7a3660a89ecaf32466ef97, 128'ha0fafe1788542cb123a339392a6c7605,
                128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

    // reset state
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_ready", 128'(ready_out), 128'(1));
    chk("rst_state", 128'(core_state_out), 128'(0));
    chk("rst_ct_valid", 128'(ct_valid_out), 128'(0));
    chk("rst_err", 128'(err_out), 128'(0));
    chk("rst_ct", ct, '0);
    chk("rst_core_pt", core_pt, '0);
    chk("rst_core_key", core_key, '0);
    RST = 1'b1;
    @(posedge CLK); #1;

    // table-driven blocks, each with one idle cycle in between
    for (int i = 0; i < 3; i++) begin
      run_block(vecs[i], 1'b0);
      ack_done(1'b0);
      @(posedge CLK); #1;
    end

    // back-pressure: hold result 20 cycles, start pulses ignored
    run_block(vecs[0], 1'b0);
    for (int i = 0; i < 20; i++) begin
      start_in = (i % 2 == 0);
      @(posedge CLK); #1;
      chk("bp_ct_valid", 128'(ct_valid_out), 128'(1));
      chk("bp_ct", ct, vecs[0].ct);
      chk("bp_ready", 128'(ready_out), 128'(0));
      chk("bp_state", 128'(core_state_out), 128'(0));
    end
    // ack together with start: start is not taken
    ack_done(1'b1);
    @(posedge CLK); #1;
    chk("no_start_on_ack", 128'(core_state_out), 128'(0));

    // reset during the 5th round1-9 cycle
    pt = vecs[0].pt; key = vecs[0].key; start_in = 1'b1;
    @(posedge CLK); #1;
    start_in = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    chk("mid_state_pre", 128'(core_state_out), 128'(2));
    RST = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b1;
    chk("mrst_ready", 128'(ready_out), 128'(1));
    chk("mrst_state", 128'(core_state_out), 128'(0));
    chk("mrst_ct_valid", 128'(ct_valid_out), 128'(0));
    chk("mrst_ct", ct, '0);
    chk("mrst_core_pt", core_pt, '0);
    chk("mrst_core_key", core_key, '0);
    run_block(vecs[0], 1'b0);
    ack_done(1'b0);

    // missing core valid: sticky error until the next accepted start
    force_inv = 1'b1;
    run_block(vecs[1], 1'b1);
    force_inv = 1'b0;
    ack_done(1'b0);
    chk("err_idle", 128'(err_out), 128'(1));
    repeat (3) @(posedge CLK);
    #1;
    chk("err_idle_hold", 128'(err_out), 128'(1));
    run_block(vecs[0], 1'b0);
    ack_done(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // overall time bound
  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/aes128_cipher_ctrl.md
Name: aes128_cipher_ctrl

Overview:
Sequencer and on-the-fly key scheduler for the iterative AES-128 encryption datapath (Cipher core).
- Accepts one plaintext/key block through a valid/ready handshake.
- Drives the core's 2-bit round state and a fresh 128-bit round key every cycle.
- Captures the core's ciphertext on its one-cycle valid pulse and holds it until the consumer acknowledges.
- Sits between the host interface and the Cipher core. The block encrypts one block at a time (no overlap).

Parameters:
ERR_CHECK, 1, when 1 a missing core valid pulse in the capture cycle sets err_out; when 0 the ciphertext is captured unconditionally.

Ports:
CLK  input  1  clock, all logic on rising edge
RST  input  1  reset, synchronous, active-low
start_in  input  1  request; block accepted on an edge where start_in=1 and ready_out=1
pt0_in..pt3_in  input  32 each  plaintext words, pt0 = most significant (FIPS-197 byte order)
key0_in..key3_in  input  32 each  cipher key words, key0 = most significant
ready_out  output  1  high only in C_IDLE
ct_valid_out  output  1  ciphertext held valid (C_DONE)
ct_ack_in  input  1  consumer accepts ciphertext while ct_valid_out=1
ct0_out..ct3_out  output  32 each  captured ciphertext words
err_out  output  1  sticky error; cleared only by reset or by acceptance of the next start
core_state_out  output  2  to Cipher state_in: 0=IDLE, 1=ROUND0, 2=ROUND1to9, 3=ROUND10
core_pt0_out..core_pt3_out  output  32 each  latched plaintext to Cipher plaintext inputs
core_key0_out..core_key3_out  output  32 each  current round key to Cipher key inputs
core_ct0_in..core_ct3_in  input  32 each  Cipher ciphertext outputs
core_valid_in  input  1  Cipher valid_out

Behaviour:
Reset
- RST=0 at a rising edge sets the FSM to C_IDLE.
- It also clears all data registers, the round counter, rcon (to 8'h01), ct_valid_out and err_out.
- After reset: ready_out=1, core_state_out=0, all ct/core outputs 0.
- Reset mid-operation abandons the block; the core sees state 0 from the next cycle.

FSM (registered state; core_state_out decoded from FSM state)
- C_IDLE: core_state=0.
  - On start_in & ready_out, latch pt*_in into the pt registers and key*_in into the round-key register rk; rcon<=01; err<=0.
  - Next state: C_R0.
- C_R0: core_state=1; core_key=rk (cipher key).
  - At the edge: rk<=expand(rk,rcon); rcon<=xtime(rcon); cnt<=1; go to C_R19.
- C_R19: core_state=2; core_key=rk (round key cnt).
  - Each edge: rk<=expand, rcon<=xtime, cnt<=cnt+1.
  - When cnt==9 at the edge, go to C_R10 instead. C_R19 lasts exactly 9 cycles.
- C_R10: core_state=3; core_key=rk (round key 10). Next state: C_CAP.
- C_CAP: core_state=0. The core presents its result with valid=1 in this cycle.
  - ct regs<=core_ct*_in.
  - If ERR_CHECK and core_valid_in=0, err_out<=1.
  - Next state: C_DONE.
- C_DONE: core_state=0; ct_valid_out=1; ct regs stable.
  - On ct_ack_in go to C_IDLE; ct_valid_out drops the following cycle.

Timing and handshake rules
- Latency: start accepted at edge E0 gives ct_valid_out=1 immediately after edge E0+12.
- Minimum block-to-block: 13 cycles plus 1 idle cycle.
- start_in outside C_IDLE is ignored; no queueing.
- ct_ack_in outside C_DONE is ignored.
- ack and start in the same cycle: the start is not accepted, because ready_out=0 in C_DONE.

Key expansion (combinational, standard AES-128)
- t = SubWord(RotWord(w3)) ^ {rcon,24'h0}
- w0'=w0^t; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
- xtime(r) = (r<<1) ^ (r[7] ? 8'h1B : 0), 8-bit.
- rcon sequence for rounds 1..10: 01,02,04,08,10,20,40,80,1B,36.
- SubWord may reuse the codebase SubByte (word on S0_in, rest tied 0).
- Latched pt registers are held constant from C_R0 through C_DONE.

Test Plan:
- FIPS-197 C.1: pt 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f -> ct 69c4e0d86a7b0430d8cdb78070b4c55a, ct_valid_out exactly 12 edges after accept, err_out=0.
- FIPS-197 App B: pt 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c -> ct 3925841d02dc09fbdc118597196a0b32; core_key in C_R10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- Sequence check, C.1 key -> core_state 1,2×9,3,0; core_key during C_R0 = 000102030405060708090a0b0c0d0e0f and during the first C_R19 cycle = d6aa74fdd2af72fadaa678f1d6ab76fe.
- Back-pressure: hold ct_ack_in=0 for 20 cycles -> ct_valid_out and ct words stable, ready_out=0, start_in pulses ignored; ack then ready_out=1 the next cycle.
- Reset mid-round: RST=0 during the 5th C_R19 cycle -> next cycle ready_out=1, core_state_out=0, ct_valid_out=0, all outputs 0; a new C.1 block then completes correctly.
- ERR_CHECK=1 with core_valid_in forced 0 in C_CAP -> err_out=1 stays set through C_DONE and C_IDLE, and clears on the next accepted start.
